regfile_alu_datapath: RTL and testbench

//   Execution datapath driven by the sequencing FSMs' control words: 16x16 register file, ALU, flag register, result bus.

---
 rtl/regfile_alu_datapath_pkg.sv | 42 ++++
 rtl/regfile_alu_datapath_if.sv | 33 +++
 rtl/regfile_alu_datapath_alu16.sv | 80 ++++++++
 rtl/regfile_alu_datapath.sv | 117 +++++++++++
 tb/tb_regfile_alu_datapath.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_alu_datapath_pkg.sv
// Shared definitions for the register-file / ALU datapath.
//   - DW, NREGS : default datapath width and register count
//   - OP_*      : ALU opcode encodings carried on alu_op
//   - FLG_*     : bit positions inside the {N,Z,F,L,C} flag vector
//   - flg_mask  : helper building a flag-update mask from flag indices
package regfile_alu_datapath_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned NREGS = 16;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_AND = 8'h01;
  localparam logic [7:0] OP_OR  = 8'h02;
  localparam logic [7:0] OP_XOR = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h05;
  localparam logic [7:0] OP_SUB = 8'h09;
  localparam logic [7:0] OP_CMP = 8'h0B;
  localparam logic [7:0] OP_SHL = 8'h0C;
  localparam logic [7:0] OP_MOV = 8'h0D;
  localparam logic [7:0] OP_SHR = 8'h0E;

  localparam int unsigned FLG_C = 0;
  localparam int unsigned FLG_L = 1;
  localparam int unsigned FLG_F = 2;
  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_N = 4;

  typedef logic [4:0] flags_t;

  function automatic flags_t flg_mask(input logic c, input logic l, input logic f,
                                      input logic z, input logic n);
    flags_t m;
    m        = '0;
    m[FLG_C] = c;
    m[FLG_L] = l;
    m[FLG_F] = f;
    m[FLG_Z] = z;
    m[FLG_N] = n;
    return m;
  endfunction

endpackage

// File: rtl/regfile_alu_datapath_if.sv
// Control-word / result-bus interface between the sequencing FSM and the datapath.
//   master : control side (drives the control word, observes bus/flags/pulses)
//   slave  : datapath side
// Signals: ctrl_valid, alu_op[7:0], mux_a[4:0], mux_b[4:0], imm[DW-1:0], imm_control,
//          regs_en[NREGS-1:0], buff_en  -> datapath
//          bus_out[DW-1:0], bus_valid, flags[4:0] {N,Z,F,L,C}, illegal_op <- datapath
interface regfile_alu_datapath_if #(
  parameter int unsigned DW    = 16,
  parameter int unsigned NREGS = 16
);
  logic             ctrl_valid;
  logic [7:0]       alu_op;
  logic [4:0]       mux_a;
  logic [4:0]       mux_b;
  logic [DW-1:0]    imm;
  logic             imm_control;
  logic [NREGS-1:0] regs_en;
  logic             buff_en;
  logic [DW-1:0]    bus_out;
  logic             bus_valid;
  logic [4:0]       flags;
  logic             illegal_op;

  modport master (
    output ctrl_valid, alu_op, mux_a, mux_b, imm, imm_control, regs_en, buff_en,
    input  bus_out, bus_valid, flags, illegal_op
  );

  modport slave (
    input  ctrl_valid, alu_op, mux_a, mux_b, imm, imm_control, regs_en, buff_en,
    output bus_out, bus_valid, flags, illegal_op
  );
endinterface

// File: rtl/regfile_alu_datapath_alu16.sv
// Combinational ALU for the datapath.
// Ports:
//   a, b      in  DW   operands
//   op        in  8    opcode (OP_* encodings)
//   result    out DW   ALU result (CMP: a-b; NOP/undefined: 0)
//   c,f,z,n,l out 1    candidate flag values
//   flag_upd  out 5    which flag bits this op updates ({N,Z,F,L,C} layout)
//   writes    out 1    op writes the register file
//   legal     out 1    op is a defined encoding
module alu16
  import regfile_alu_datapath_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [7:0]    op,
  output logic [DW-1:0] result,
  output logic          c,
  output logic          f,
  output logic          z,
  output logic          n,
  output logic          l,
  output flags_t        flag_upd,
  output logic          writes,
  output logic          legal
);

  logic [DW:0] sum;
  logic [DW:0] diff;
  logic [3:0]  shamt;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[3:0];

  always_comb begin
    result   = '0;
    c        = 1'b0;
    f        = 1'b0;
    l        = 1'b0;
    writes   = 1'b0;
    legal    = 1'b1;
    flag_upd = '0;
    case (op)
      OP_AND: begin result = a & b;       writes = 1'b1; flag_upd = flg_mask(0, 0, 0, 1, 1); end
      OP_OR:  begin result = a | b;       writes = 1'b1; flag_upd = flg_mask(0, 0, 0, 1, 1); end
      OP_XOR: begin result = a ^ b;       writes = 1'b1; flag_upd = flg_mask(0, 0, 0, 1, 1); end
      OP_SHL: begin result = a << shamt;  writes = 1'b1; flag_upd = flg_mask(0, 0, 0, 1, 1); end
      OP_SHR: begin result = a >> shamt;  writes = 1'b1; flag_upd = flg_mask(0, 0, 0, 1, 1); end
      OP_MOV: begin result = b;           writes = 1'b1; flag_upd = flg_mask(0, 0, 0, 1, 1); end
      OP_ADD: begin
        result   = sum[DW-1:0];
        c        = sum[DW];
        // Overflow: like-signed operands produced an opposite-signed result.
        f        = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
        writes   = 1'b1;
        flag_upd = flg_mask(1, 0, 1, 1, 1);
      end
      OP_SUB: begin
        result   = diff[DW-1:0];
        c        = diff[DW];  // borrow
        f        = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
        writes   = 1'b1;
        flag_upd = flg_mask(1, 0, 1, 1, 1);
      end
      OP_CMP: begin
        result   = diff[DW-1:0];
        l        = (a < b);
        flag_upd = flg_mask(0, 1, 0, 1, 1);
      end
      OP_NOP:  ;
      default: legal = 1'b0;
    endcase
    z = (result == '0);
    // CMP reports a signed less-than on N rather than the sign of the difference.
    n = (op == OP_CMP) ? ($signed(a) < $signed(b)) : result[DW-1];
  end

endmodule

// File: rtl/regfile_alu_datapath.sv
// Execution datapath: NREGS x DW register file, ALU, flag register and result bus.
// One control word executes per cycle with ctrl_valid=1.
// Ports:
//   clk    in  system clock, all state on posedge
//   reset  in  asynchronous active-low reset
//   dp     slave modport of regfile_alu_datapath_if (control word in, bus/flags/pulses out)
// Configuration: define DP_FLAGS_EN to implement the {N,Z,F,L,C} flag register;
// otherwise flags read 0 and CMP only publishes A-B on the bus.
module regfile_alu_datapath
  import regfile_alu_datapath_pkg::*;
#(
  parameter int unsigned DW    = regfile_alu_datapath_pkg::DW,
  parameter int unsigned NREGS = regfile_alu_datapath_pkg::NREGS
) (
  input logic                  clk,
  input logic                  reset,
  regfile_alu_datapath_if.slave dp
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;

  logic [DW-1:0] alu_result;
  logic          alu_c, alu_f, alu_z, alu_n, alu_l;
  flags_t        alu_upd;
  logic          alu_writes;
  logic          alu_legal;

  logic [DW-1:0] bus_q;
  logic          bus_valid_q;
  logic          illegal_q;

  // Selects beyond the implemented registers read as zero.
  always_comb begin
    opa = '0;
    opb = '0;
    if (32'(dp.mux_a) < NREGS) opa = regs_q[dp.mux_a[AW-1:0]];
    if (dp.imm_control)                 opb = dp.imm;
    else if (32'(dp.mux_b) < NREGS)     opb = regs_q[dp.mux_b[AW-1:0]];
  end

  alu16 #(
    .DW(DW)
  ) u_alu (
    .a        (opa),
    .b        (opb),
    .op       (dp.alu_op),
    .result   (alu_result),
    .c        (alu_c),
    .f        (alu_f),
    .z        (alu_z),
    .n        (alu_n),
    .l        (alu_l),
    .flag_upd (alu_upd),
    .writes   (alu_writes),
    .legal    (alu_legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (dp.ctrl_valid && alu_writes) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (dp.regs_en[i]) regs_q[i] <= alu_result;
      end
    end
  end

`ifdef DP_FLAGS_EN
  flags_t flags_q;
  flags_t alu_flags;

  always_comb begin
    alu_flags        = '0;
    alu_flags[FLG_C] = alu_c;
    alu_flags[FLG_L] = alu_l;
    alu_flags[FLG_F] = alu_f;
    alu_flags[FLG_Z] = alu_z;
    alu_flags[FLG_N] = alu_n;
  end

  // Only the bits the op defines are replaced; the rest hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else if (dp.ctrl_valid && alu_legal) begin
      flags_q <= (flags_q & ~alu_upd) | (alu_flags & alu_upd);
    end
  end

  assign dp.flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^{alu_c, alu_f, alu_z, alu_n, alu_l, alu_upd};
  assign dp.flags     = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_q       <= '0;
      bus_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      bus_valid_q <= dp.ctrl_valid && dp.buff_en;
      illegal_q   <= dp.ctrl_valid && !alu_legal;
      if (dp.ctrl_valid && dp.buff_en) bus_q <= alu_result;
    end
  end

  assign dp.bus_out    = bus_q;
  assign dp.bus_valid  = bus_valid_q;
  assign dp.illegal_op = illegal_q;

endmodule

// File: tb/tb_regfile_alu_datapath.sv
module tb_regfile_alu_datapath;
  import regfile_alu_datapath_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_alu_datapath_if #(.DW(16), .NREGS(16)) dp_if ();

  regfile_alu_datapath #(.DW(16), .NREGS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state
  logic [15:0] m_regs [16];
  logic [4:0]  m_flags;
  logic [15:0] m_bus;
  logic        m_bv;
  logic        m_ill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [4:0] s);
    if (s < 5'd16) return m_regs[s[3:0]];
    return 16'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_flags = 5'h0; m_bus = 16'h0; m_bv = 1'b0; m_ill = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".bus_out"},    dp_if.bus_out,    m_bus);
    chk({tag, ".bus_valid"},  dp_if.bus_valid,  m_bv);
    chk({tag, ".illegal_op"}, dp_if.illegal_op, m_ill);
    chk({tag, ".flags"},      dp_if.flags,      m_flags);
  endtask

  // Drive one control word, predict its effect from the opcode rules, check after the edge.
  task automatic step(input string tag, input logic valid, input logic [7:0] op,
                      input logic [4:0] ma, input logic [4:0] mb, input logic [15:0] im,
                      input logic ic, input logic [15:0] en, input logic be);
    logic [15:0] a, b, res;
    int ua, ub, sa, sb, full;
    logic legal, wr, zn;
    logic [4:0] nf;
    @(negedge clk);
    dp_if.ctrl_valid = valid; dp_if.alu_op = op; dp_if.mux_a = ma; dp_if.mux_b = mb;
    dp_if.imm = im; dp_if.imm_control = ic; dp_if.regs_en = en; dp_if.buff_en = be;
    a = rd(ma);
    b = ic ? im : rd(mb);
    ua = int'(a); ub = int'(b); sa = int'($signed(a)); sb = int'($signed(b));
    legal = 1'b1; wr = 1'b1; zn = 1'b1; nf = m_flags; res = 16'h0;
    case (op)
      8'h01: res = a & b;
      8'h02: res = a | b;
      8'h03: res = a ^ b;
      8'h0D: res = b;
      8'h0C: res = 16'((ua << (ub % 16)) % 65536);
      8'h0E: res = 16'(ua >> (ub % 16));
      8'h05: begin
        full = ua + ub; res = 16'(full % 65536);
        nf[FLG_C] = (full > 65535);
        nf[FLG_F] = (sa + sb > 32767) || (sa + sb < -32768);
      end
      8'h09: begin
        full = ua - ub; res = 16'(full);
        nf[FLG_C] = (ua < ub);
        nf[FLG_F] = (sa - sb > 32767) || (sa - sb < -32768);
      end
      8'h0B: begin
        res = 16'(ua - ub); wr = 1'b0; zn = 1'b0;
        nf[FLG_Z] = (ua == ub); nf[FLG_L] = (ua < ub); nf[FLG_N] = (sa < sb);
      end
      8'h00: begin wr = 1'b0; zn = 1'b0; end
      default: begin legal = 1'b0; wr = 1'b0; zn = 1'b0; end
    endcase
    if (zn) begin
      nf[FLG_Z] = (res == 16'h0);
      nf[FLG_N] = res[15];
    end
`ifndef DP_FLAGS_EN
    nf = 5'h0;
`endif
    @(posedge clk);
    #1;
    if (valid) begin
      if (wr) for (int i = 0; i < 16; i++) if (en[i]) m_regs[i] = res;
      if (legal) m_flags = nf;
      if (be) m_bus = res;
      m_bv = be; m_ill = !legal;
    end else begin
      m_bv = 1'b0; m_ill = 1'b0;
    end
    check_outputs(tag);
  endtask

  // Publish R[s] on the bus without writing anything (OR with imm 0).
  task automatic readback(input string tag, input logic [4:0] s);
    step(tag, 1'b1, OP_OR, s, 5'd0, 16'h0, 1'b1, 16'h0, 1'b1);
    chk({tag, ".value"}, dp_if.bus_out, rd(s));
  endtask

  localparam logic [7:0] OPS [10] = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h09,
                                      8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h00};

  initial begin
    logic [7:0] op;
    logic be;
    dp_if.ctrl_valid = 0; dp_if.alu_op = 0; dp_if.mux_a = 0; dp_if.mux_b = 0;
    dp_if.imm = 0; dp_if.imm_control = 0; dp_if.regs_en = 0; dp_if.buff_en = 0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Fibonacci chain
    step("fib1", 1, OP_ADD, 5'd0, 5'd0, 16'd1, 1, 16'h0002, 1);
    for (int k = 2; k < 16; k++)
      step("fibk", 1, OP_ADD, 5'(k - 2), 5'(k - 1), 16'h0, 0, 16'(1 << k), 1);
    chk("fib_r15", dp_if.bus_out, 32'd610);

    // Signed overflow and carry
    step("mov7fff", 1, OP_MOV, 5'd0, 5'd0, 16'h7FFF, 1, 16'h0002, 0);
    step("add_ovf", 1, OP_ADD, 5'd1, 5'd0, 16'h0001, 1, 16'h0004, 1);
    chk("add_ovf_res", dp_if.bus_out, 32'h8000);
    step("movffff", 1, OP_MOV, 5'd0, 5'd0, 16'hFFFF, 1, 16'h0002, 0);
    step("add_cry", 1, OP_ADD, 5'd1, 5'd0, 16'h0001, 1, 16'h0004, 1);
    chk("add_cry_res", dp_if.bus_out, 32'h0000);

    // CMP never writes
    step("mov5", 1, OP_MOV, 5'd0, 5'd0, 16'd5, 1, 16'h0004, 0);
    step("cmp", 1, OP_CMP, 5'd2, 5'd0, 16'd9, 1, 16'hFFFF, 1);
    chk("cmp_bus", dp_if.bus_out, 32'hFFFC);
    readback("cmp_r2", 5'd2);
    readback("cmp_r7", 5'd7);

    // Multi-hot MOV and out-of-range select
    step("mov_mh", 1, OP_MOV, 5'd0, 5'd0, 16'h00AA, 1, 16'h8421, 0);
    for (int i = 0; i < 16; i += 5) readback("mh_rd", 5'(i));
    readback("sel20", 5'd20);
    chk("sel20_zero", dp_if.bus_out, 32'h0);

    // Idle word and illegal opcode
    step("idle", 0, OP_MOV, 5'd0, 5'd0, 16'h1234, 1, 16'hFFFF, 1);
    readback("idle_r3", 5'd3);
    step("illegal", 1, 8'h77, 5'd1, 5'd2, 16'h5555, 1, 16'hFFFF, 0);
    chk("illegal_pulse", dp_if.illegal_op, 32'h1);
    step("after_ill", 1, OP_NOP, 5'd0, 5'd0, 16'h0, 0, 16'h0, 0);
    readback("ill_r4", 5'd4);

    // Randomised words
    for (int it = 0; it < 300; it++) begin
      op = OPS[$urandom_range(0, 9)];
      be = $urandom_range(0, 1) == 1 && op != OP_NOP;
      step("rand", ($urandom % 8) != 0, op, 5'($urandom_range(0, 17)),
           5'($urandom_range(0, 17)), 16'($urandom), 1'($urandom_range(0, 1)),
           16'($urandom), be);
      if (it % 25 == 0) readback("rand_rd", 5'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-sequence
    step("pre_rst", 1, OP_MOV, 5'd0, 5'd0, 16'hBEEF, 1, 16'h0020, 1);
    @(negedge clk);
    dp_if.ctrl_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    readback("rst_r5", 5'd5);
    step("recover", 1, OP_ADD, 5'd0, 5'd0, 16'h0042, 1, 16'h0020, 1);
    readback("rec_r5", 5'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
